muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for a single-issue pipeline.
// Runs one shift-add (multiply) or restoring (divide) step per cycle for 32 cycles,
// then emits a one-cycle done pulse with the sign-corrected result.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            op request from Execute, held until done
//   funct3           000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                    100 DIV, 101 DIVU, 110 REM, 111 REMU
//   a, b             rs1 / rs2 operands
//   flush            abort the current op
//   busy             state is not IDLE
//   done             single-cycle completion pulse
//   result           registered result, held until the next completion
//   stall            combinational start & ~done, freezes the F/D/E registers
//
// Optional feature: define MULDIV_ZERO_SKIP_EN to skip CALC for a divide by zero or a
// multiply with a zero operand (IDLE -> DONE, done in cycle 1).
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        stall
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   mag_a_q, mag_b_q;
  logic              neg_a_q, neg_b_q, b_zero_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed_c, b_signed_c, a_neg_c, b_neg_c;
  logic [XLEN-1:0]   mag_a_c, mag_b_c;
  logic              launch_c, skip_c;
  logic [XLEN:0]     add_c, rem_sh_c, diff_c;
  logic [XLEN-1:0]   hi_n, lo_n, fixed_c;
  logic [2*XLEN-1:0] prod_c, prod_fix_c;
  logic [XLEN-1:0]   quo_fix_c, rem_fix_c;

  // Operand signedness per funct3
  always_comb begin
    a_signed_c = 1'b0;
    b_signed_c = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed_c = 1'b1;
        b_signed_c = 1'b1;
      end
      3'b010:  a_signed_c = 1'b1;
      default: ;
    endcase
  end

  assign a_neg_c  = a_signed_c & a[XLEN-1];
  assign b_neg_c  = b_signed_c & b[XLEN-1];
  assign mag_a_c  = a_neg_c ? -a : a;
  assign mag_b_c  = b_neg_c ? -b : b;
  assign launch_c = (state_q == S_IDLE) & start & ~flush;

`ifdef MULDIV_ZERO_SKIP_EN
  logic            zero_op_c;
  logic [XLEN-1:0] skip_res_c;
  // Divide by zero or multiply by zero has a known answer without iterating
  assign zero_op_c  = funct3[2] ? (b == '0) : ((a == '0) | (b == '0));
  assign skip_res_c = !funct3[2] ? '0 : (funct3[1] ? a : '1);
  assign skip_c     = zero_op_c;
`else
  assign skip_c     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides everything but reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch_c) state_d = skip_c ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == LAST_ITER) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Output logic; result only moves on a real entry into DONE
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    result_d = result_q;
    if ((state_q == S_CALC) && (state_d == S_DONE)) result_d = fixed_c;
`ifdef MULDIV_ZERO_SKIP_EN
    if ((state_q == S_IDLE) && (state_d == S_DONE)) result_d = skip_res_c;
`endif
  end

  // One iteration: shift-add on {hi,lo} for multiply, restoring step for divide
  always_comb begin
    add_c    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);
    rem_sh_c = {hi_q, lo_q[XLEN-1]};
    diff_c   = rem_sh_c - {1'b0, mag_b_q};
    hi_n     = hi_q;
    lo_n     = lo_q;
    if (op_q[2]) begin
      if (!diff_c[XLEN]) begin
        hi_n = diff_c[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_n = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = add_c[XLEN:1];
      lo_n = {add_c[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix on the final iteration's output; divide-by-zero quotient is never negated
  always_comb begin
    prod_c     = {hi_n, lo_n};
    prod_fix_c = (neg_a_q ^ neg_b_q) ? -prod_c : prod_c;
    quo_fix_c  = b_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -lo_n : lo_n);
    rem_fix_c  = neg_a_q ? -hi_n : hi_n;
    case (op_q)
      3'b000:                 fixed_c = prod_fix_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fixed_c = prod_fix_c[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fixed_c = quo_fix_c;
      default:                fixed_c = rem_fix_c;
    endcase
  end

  // Datapath: capture at launch, iterate in CALC
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
    end else if (launch_c) begin
      op_q     <= funct3;
      mag_a_q  <= mag_a_c;
      mag_b_q  <= mag_b_c;
      neg_a_q  <= a_neg_c;
      neg_b_q  <= b_neg_c;
      b_zero_q <= (b == '0);
      hi_q     <= '0;
      lo_q     <= funct3[2] ? mag_a_c : mag_b_c;
      cnt_q    <= '0;
    end else if ((state_q == S_CALC) && !flush) begin
      hi_q     <= hi_n;
      lo_q     <= lo_n;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign stall  = start & ~done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer: hand-computed results and latencies.
// Cycle 0 is the cycle in which start is first sampled; outputs are sampled 1 time unit
// after each rising edge.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

`ifdef MULDIV_ZERO_SKIP_EN
  localparam int ZL = 1;
`else
  localparam int ZL = 33;
`endif

  muldiv_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op in cycle 0, scramble inputs from cycle 1, wait for done (bounded)
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ex, input int lat_exp);
    int   lat;
    logic busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    funct3  = f;
    a       = av;
    b       = bv;
    start   = 1'b1;
    #1;
    check({tag, "_stall_req"}, 32'(stall), 32'd1);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        funct3 = ~f;
        a      = 32'hDEADBEEF;
        b      = 32'h00000003;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) lat = k;
    end
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    check({tag, "_res"}, result, ex);
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'({busy, done}), 32'd0);
    check({tag, "_hold"}, result, ex);
  endtask

  initial begin
    int   lat;
    logic early;
    reset  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    a      = '0;
    b      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Multiply
    run_op("mul_neg3x7",  3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 33);
    run_op("mulhu_ones",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh_ones",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run_op("mulh_min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhsu_min",  3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run_op("mul_zero",    3'b000, 32'h00000000, 32'h00012345, 32'h00000000, ZL);

    // Divide
    run_op("div_neg7_2",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem_neg7_2",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_op("div_pos_m2",  3'b100, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'hC0000001, 33);
    run_op("rem_pos_m2",  3'b110, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    run_op("div_5_by0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, ZL);
    run_op("rem_5_by0",   3'b110, 32'd5,        32'd0,        32'd5,        ZL);
    run_op("div_m5_by0",  3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, ZL);
    run_op("remu_by0",    3'b111, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, ZL);
    run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);

    // Flush in cycle 10 of a DIV, restart in cycle 11
    funct3 = 3'b100;
    a      = 32'd100;
    b      = 32'd7;
    start  = 1'b1;
    early  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) early = 1'b1;
    end
    check("flush_busy_c10", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_idle_c11", 32'(busy), 32'd0);
    check("flush_no_done", 32'({done, early}), 32'd0);
    check("flush_res_held", result, 32'h00000000);
    flush  = 1'b0;
    funct3 = 3'b101;
    lat    = 0;
    for (int k = 12; k <= 60 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat = k;
    end
    check("restart_lat", 32'(lat), 32'd44);
    check("restart_res", result, 32'd14);
    start = 1'b0;
    @(posedge clk); #1;

    // Reset in cycle 20 of a MUL
    funct3 = 3'b000;
    a      = 32'hFFFFFFFD;
    b      = 32'd7;
    start  = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("rstmid_busy_c20", 32'(busy), 32'd1);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rstmid_outs", 32'({busy, done, stall}), 32'd0);
    check("rstmid_result", result, 32'h0);
    reset = 1'b0;
    early = 1'b0;
    for (int k = 22; k <= 40; k++) begin
      @(posedge clk); #1;
      if ((done === 1'b1) || (busy === 1'b1)) early = 1'b1;
    end
    check("rstmid_no_done", 32'(early), 32'd0);

    // start and flush together in IDLE: flush wins
    funct3 = 3'b100;
    a      = 32'd100;
    b      = 32'd7;
    start  = 1'b1;
    flush  = 1'b1;
    @(posedge clk); #1;
    check("startflush_busy", 32'(busy), 32'd0);
    start = 1'b0;
    flush = 1'b0;
    @(posedge clk); #1;
    check("startflush_after", 32'({busy, done}), 32'd0);
    check("startflush_res", result, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
